// File: rtl/arm_pipe_pkg.sv
// Shared constants for the ARM pipeline stage registers: control-bit positions,
// default widths and the occupancy state encoding.
package arm_pipe_pkg;

  localparam int unsigned CTRL_WB_EN    = 0;
  localparam int unsigned CTRL_MEM_R_EN = 1;
  localparam int unsigned CTRL_MEM_W_EN = 2;
  localparam int unsigned CTRL_S        = 3;
  localparam int unsigned CTRL_B        = 4;
  localparam int unsigned CTRL_IMM      = 5;

  localparam int unsigned ARM_CTRL_W    = 8;
  localparam int unsigned ARM_PAYLOAD_W = 160;
  localparam int unsigned ARM_CNT_W     = 16;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

endpackage

// File: rtl/arm_pipe_slot.sv
// One storage entry of the stage register: valid flag, control vector and payload.
// Clearing drops only the valid flag; the payload keeps its last value.
module arm_pipe_slot
  import arm_pipe_pkg::*;
#(
  parameter int unsigned CTRL_W    = ARM_CTRL_W,
  parameter int unsigned PAYLOAD_W = ARM_PAYLOAD_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic                 clr_i,
  input  logic [CTRL_W-1:0]    ctrl_i,
  input  logic [PAYLOAD_W-1:0] data_i,
  output logic                 valid_o,
  output logic [CTRL_W-1:0]    ctrl_o,
  output logic [PAYLOAD_W-1:0] data_o
);

  logic                 valid_q;
  logic [CTRL_W-1:0]    ctrl_q;
  logic [PAYLOAD_W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      ctrl_q  <= ctrl_i;
      data_q  <= data_i;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/arm_pipe_stage_reg.sv
// Elastic inter-stage register with optional two-entry skid buffer, synchronous
// flush and a saturating count of flushes that killed at least one beat.
module arm_pipe_stage_reg
  import arm_pipe_pkg::*;
#(
  parameter int unsigned CTRL_W    = ARM_CTRL_W,
  parameter int unsigned PAYLOAD_W = ARM_PAYLOAD_W,
  parameter int unsigned SKID      = 1,
  parameter int unsigned CNT_W     = ARM_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CTRL_W-1:0]    in_ctrl,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CTRL_W-1:0]    out_ctrl,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic [1:0]           occ,
  output logic [CNT_W-1:0]     flush_cnt
);

  logic [1:0]           occ_q, occ_d;
  logic [CNT_W-1:0]     flush_cnt_q;
  logic                 accept, deliver, kill;
  logic                 head_load, head_clr, head_from_skid;
  logic                 skid_load, skid_clr;
  logic                 head_v, skid_v;
  logic [CTRL_W-1:0]    head_ctrl, skid_ctrl, head_ctrl_d;
  logic [PAYLOAD_W-1:0] head_data, skid_data, head_data_d;

  assign accept  = in_valid & in_ready & ~flush;
  assign deliver = head_v & out_ready;
  assign kill    = flush & ((occ_q != OCC_EMPTY) | in_valid);

  always_comb begin
    occ_d          = occ_q;
    head_load      = 1'b0;
    head_clr       = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      occ_d    = OCC_EMPTY;
      head_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (accept) begin
            head_load = 1'b1;
            occ_d     = OCC_ONE;
          end
        end
        OCC_ONE: begin
          // Accept without deliver is only reachable with the skid entry present.
          if (accept && deliver) begin
            head_load = 1'b1;
          end else if (accept) begin
            skid_load = 1'b1;
            occ_d     = OCC_FULL;
          end else if (deliver) begin
            head_clr = 1'b1;
            occ_d    = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (deliver) begin
            head_load      = 1'b1;
            head_from_skid = 1'b1;
            skid_clr       = 1'b1;
            occ_d          = OCC_ONE;
          end
        end
        default: begin
          occ_d    = OCC_EMPTY;
          head_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  assign head_ctrl_d = head_from_skid ? skid_ctrl : in_ctrl;
  assign head_data_d = head_from_skid ? skid_data : in_data;

  arm_pipe_slot #(
    .CTRL_W    (CTRL_W),
    .PAYLOAD_W (PAYLOAD_W)
  ) u_head (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (head_load),
    .clr_i   (head_clr),
    .ctrl_i  (head_ctrl_d),
    .data_i  (head_data_d),
    .valid_o (head_v),
    .ctrl_o  (head_ctrl),
    .data_o  (head_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic in_ready_q;

      arm_pipe_slot #(
        .CTRL_W    (CTRL_W),
        .PAYLOAD_W (PAYLOAD_W)
      ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (skid_load),
        .clr_i   (skid_clr),
        .ctrl_i  (in_ctrl),
        .data_i  (in_data),
        .valid_o (skid_v),
        .ctrl_o  (skid_ctrl),
        .data_o  (skid_data)
      );

      // Registered from the next occupancy so out_ready never reaches in_ready.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) in_ready_q <= 1'b0;
        else        in_ready_q <= (occ_d != OCC_FULL);
      end

      assign in_ready = in_ready_q;
    end else begin : g_noskid
      assign skid_v    = 1'b0;
      assign skid_ctrl = '0;
      assign skid_data = '0;
      assign in_ready  = ~head_v | out_ready;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q       <= OCC_EMPTY;
      flush_cnt_q <= '0;
    end else begin
      occ_q <= occ_d;
      if (kill && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign out_valid = head_v;
  assign out_ctrl  = head_v ? head_ctrl : '0;
  assign out_data  = head_data;
  assign occ       = occ_q;
  assign flush_cnt = flush_cnt_q;

endmodule
